// File: rtl/uart_pkg.sv
// Shared UART package: FSM state encoding, frame width and default bit timing.
// Used by both uart_tx and uart_rx so the two ends of a link agree on format.
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int CLKS_PER_BIT_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line.
// Both stages reset to 1 so an idle-high line never shows a false falling edge.
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; only sync_q is safe to use downstream.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default. Define UART_RX_PARITY_EN for 8E1 framing,
// which adds the PARITY state and the parity_err output.
// Samples every bit at its centre, counted from the synchronized start edge.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic rx_s;

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (data_rx),
        .q     (rx_s)
    );

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_d_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    // Next-state logic: bit-period counter runs freely and is cleared at each sample point.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // Falling edge only, so a line stuck low cannot retrigger.
                if (rx_d_q && !rx_s) begin
                    state_d = ST_START;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is not missed.
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (!rx_s) begin
                        ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_q != ^shift_q) begin
                        perr_d = 1'b1;
`endif
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset discards any partial byte.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            rx_d_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            rx_d_q  <= rx_s;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule
